apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
Synthesizable APB3 initiator. Converts a simple valid/ready command interface into APB transfers on the timer's register bus, one transfer at a time. It lets an on-chip controller program and poll the timer, for example by writing TCR at 8'h01 or reading CNT. This is the hardware counterpart of the bench CPU model. Adds a wait-state timeout and a saturating error counter.

Parameters:
ADDR_W, 8, APB address width
DATA_W, 8, APB data width
TIMEOUT_CYCLES, 255, max ACCESS-phase wait cycles before abort; 0 disables the timeout
ERRCNT_W, 8, width of the saturating error counter

Ports:
pclk  in  1  clock; all logic on rising edge
preset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when a command can be accepted
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse: transfer finished
rsp_rdata  out  DATA_W  read data; valid with rsp_valid on reads
rsp_err  out  1  with rsp_valid: PSLVERR or timeout
rsp_timeout  out  1  with rsp_valid: transfer aborted by timeout
err_cnt  out  ERRCNT_W  saturating count of rsp_err events
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset (preset=1 at a pclk edge) sets every output to 0, except cmd_ready, which becomes 1 in the cycle after reset. State goes to IDLE and the timeout counter clears. Reset overrides everything, including a transfer in progress: psel and penable are 0 in the cycle after the reset edge, and no rsp_valid is issued for the aborted transfer.
- All outputs are registered. cmd_ready = (state==IDLE).
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: at an edge with cmd_valid && cmd_ready, latch cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
- SETUP (exactly one cycle): psel=1, penable=0. Next state is ACCESS.
- ACCESS: psel=1, penable=1. paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS.
  - pready=1 at an edge: capture prdata into rsp_rdata (reads only; writes leave rsp_rdata unchanged). Set rsp_err=pslverr, rsp_timeout=0, rsp_valid=1. Go to IDLE with psel=penable=0.
  - pready=0: increment the wait counter.
  - If TIMEOUT_CYCLES!=0 and the wait counter equals TIMEOUT_CYCLES at an edge with pready=0: abort. Set psel=penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, and go to IDLE.
  - pready=1 on the same edge as the timeout condition: pready wins and the transfer completes normally.
- pslverr is sampled only when pready=1 in ACCESS; it is ignored at all other times.
- Wait counter clears on every entry to SETUP.
- rsp_valid is high for exactly one cycle. That same cycle is IDLE with cmd_ready=1, so a new command can be accepted there.
- Throughput: command accepted at edge N → psel rises in cycle N+1 → ACCESS in cycle N+2 → with zero wait states, rsp_valid in cycle N+3. Back-to-back commands therefore issue one every 3 cycles.
- Outside a transfer, paddr, pwrite and pwdata hold their last values; only psel and penable return to 0.
- err_cnt increments on every rsp_valid with rsp_err=1 and saturates at all-ones (no wrap). It clears only on reset.
- cmd_* inputs are ignored when cmd_ready=0; the requester holds cmd_valid until accepted.
- APB3 only: no pprot or pstrb.

Test Plan:
- Write, no waits. Write addr 8'h01, data 8'h30, pready tied 1. Required: SETUP cycle with psel=1, penable=0; ACCESS cycle with psel=1, penable=1; paddr=8'h01, pwdata=8'h30, pwrite=1 held in both. Then rsp_valid=1 with rsp_err=0, exactly 3 cycles after accept.
- Read with waits. Read addr 8'h01, slave drives pready=0 for 3 ACCESS cycles, then pready=1 with prdata=8'h31. Required: penable high 4 cycles, rsp_rdata=8'h31, rsp_err=0, no timeout.
- Slave error. Write with pready=1, pslverr=1. Required: rsp_err=1, rsp_timeout=0, err_cnt 0→1. Then 256 further error transfers → err_cnt stays 8'hFF.
- Timeout. TIMEOUT_CYCLES=4, pready held 0. Required: abort after 4 wait cycles; psel/penable drop; rsp_valid with rsp_err=1, rsp_timeout=1. Repeat with pready=1 on the timeout edge → normal completion, rsp_timeout=0.
- Reset mid-transfer. Assert preset for 1 cycle during ACCESS. Required: psel=penable=0, rsp_valid never pulses, cmd_ready=1 the cycle after reset. Then a following read of 8'h01 completes normally.
- Back-to-back. cmd_valid held high for 4 commands: writes 8'h30, 8'h31, 8'h32, 8'h33 to 8'h01, pready=1. Required: 4 transfers, rsp_valid every 3 cycles, pwdata in order, no command dropped or duplicated.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB3 initiator: turns a valid/ready command stream into single APB transfers,
// with an ACCESS-phase wait-state timeout and a saturating error counter.
module apb_cmd_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERRCNT_W       = 8
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam int WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] TO_LIM = WAIT_W'(TIMEOUT_CYCLES);

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      err_cnt     <= '0;
      paddr       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
    end else begin
      // Response flags are single-cycle pulses; the completing branch re-asserts them.
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
            psel      <= 1'b1;
            cmd_ready <= 1'b0;
            wait_cnt  <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a timeout landing on the same edge.
          if (pready) begin
            if (!pwrite) rsp_rdata <= prdata;
            rsp_err   <= pslverr;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
            if (pslverr) err_cnt <= sat_inc(err_cnt);
          end else if (TIMEOUT_CYCLES != 0 && wait_cnt == TO_LIM) begin
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            cmd_ready   <= 1'b1;
            state       <= IDLE;
            err_cnt     <= sat_inc(err_cnt);
          end else if (TIMEOUT_CYCLES != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          psel      <= 1'b0;
          penable   <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: APB phase sequencing, wait states,
// slave errors, timeout, reset abort and back-to-back throughput.
module tb_apb_cmd_master;

  logic       pclk = 1'b0;
  logic       preset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata, err_cnt;
  logic [7:0] paddr, pwdata, prdata;
  logic       psel, penable, pwrite, pready, pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  apb_cmd_master #(
    .ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(4), .ERRCNT_W(8)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .err_cnt(err_cnt),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  // Presents one command, lets it be accepted at the next edge, then drops cmd_valid.
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    chk("issue_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    tick;
    cmd_valid = 1'b0;
  endtask

  int pen_cycles;
  int rsp_seen;
  int idx;
  int nrsp;
  int rsp_cyc[4];
  logic [7:0] acc_data[4];
  int nacc;
  logic acc;

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #1; tick; tick;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    preset = 1'b0;

    // Write with no wait states
    pready = 1'b1;
    issue(1'b1, 8'h01, 8'h30);
    chk("wr_setup_psel", psel, 1);
    chk("wr_setup_penable", penable, 0);
    chk("wr_setup_paddr", paddr, 8'h01);
    chk("wr_setup_pwdata", pwdata, 8'h30);
    chk("wr_setup_pwrite", pwrite, 1);
    chk("wr_setup_cmd_ready", cmd_ready, 0);
    tick;
    chk("wr_access_psel", psel, 1);
    chk("wr_access_penable", penable, 1);
    chk("wr_access_paddr", paddr, 8'h01);
    chk("wr_access_pwdata", pwdata, 8'h30);
    chk("wr_access_pwrite", pwrite, 1);
    chk("wr_access_rsp_valid", rsp_valid, 0);
    tick;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_timeout", rsp_timeout, 0);
    chk("wr_done_psel", psel, 0);
    chk("wr_done_penable", penable, 0);
    chk("wr_done_cmd_ready", cmd_ready, 1);
    chk("wr_hold_paddr", paddr, 8'h01);
    tick;
    chk("wr_rsp_pulse_end", rsp_valid, 0);

    // Read with three wait states
    pready = 1'b0;
    issue(1'b0, 8'h01, 8'h00);
    pen_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (rsp_valid) break;
      if (penable) pen_cycles++;
      if (pen_cycles == 4) begin pready = 1'b1; prdata = 8'h31; end
    end
    chk("rd_penable_cycles", pen_cycles, 4);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 8'h31);
    chk("rd_rsp_err", rsp_err, 0);
    chk("rd_rsp_timeout", rsp_timeout, 0);

    // Slave error on a write
    pready = 1'b1; pslverr = 1'b1; prdata = 8'hEE;
    issue(1'b1, 8'h02, 8'h55);
    tick; tick;
    chk("se_rsp_valid", rsp_valid, 1);
    chk("se_rsp_err", rsp_err, 1);
    chk("se_rsp_timeout", rsp_timeout, 0);
    chk("se_err_cnt", err_cnt, 1);
    chk("se_rdata_kept", rsp_rdata, 8'h31);
    pslverr = 1'b0;

    // Timeout: pready held low, abort on the 5th ACCESS edge (4 waits allowed)
    pready = 1'b0; pslverr = 1'b1;
    issue(1'b0, 8'h05, 8'h00);
    pen_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (rsp_valid) break;
      if (penable) pen_cycles++;
    end
    chk("to_penable_cycles", pen_cycles, 5);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_psel", psel, 0);
    chk("to_penable", penable, 0);
    chk("to_err_cnt", err_cnt, 2);
    chk("to_rdata_kept", rsp_rdata, 8'h31);
    pslverr = 1'b0;

    // pready arrives on the timeout edge: normal completion
    issue(1'b0, 8'h05, 8'h00);
    pen_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (rsp_valid) break;
      if (penable) pen_cycles++;
      if (pen_cycles == 5) begin pready = 1'b1; prdata = 8'h5A; end
    end
    chk("tw_penable_cycles", pen_cycles, 5);
    chk("tw_rsp_valid", rsp_valid, 1);
    chk("tw_rsp_err", rsp_err, 0);
    chk("tw_rsp_timeout", rsp_timeout, 0);
    chk("tw_rsp_rdata", rsp_rdata, 8'h5A);
    chk("tw_err_cnt", err_cnt, 2);

    // 256 further slave errors: counter climbs then saturates
    pready = 1'b1; pslverr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      issue(1'b1, 8'h03, 8'h00);
      tick; tick;
      if (i == 251) chk("sat_err_cnt_fe", err_cnt, 8'hFE);
      if (i == 252) chk("sat_err_cnt_ff", err_cnt, 8'hFF);
    end
    chk("sat_err_cnt_final", err_cnt, 8'hFF);
    chk("sat_rsp_err", rsp_err, 1);
    pslverr = 1'b0;
    tick;

    // Reset during ACCESS
    pready = 1'b0;
    issue(1'b0, 8'h01, 8'h00);
    tick;
    chk("mr_in_access", penable, 1);
    preset = 1'b1;
    tick;
    preset = 1'b0;
    chk("mr_psel", psel, 0);
    chk("mr_penable", penable, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_err_cnt", err_cnt, 0);
    rsp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (rsp_valid) rsp_seen++;
    end
    chk("mr_no_rsp", rsp_seen, 0);
    pready = 1'b1; prdata = 8'h31;
    issue(1'b0, 8'h01, 8'h00);
    tick; tick;
    chk("mr_rd_rsp_valid", rsp_valid, 1);
    chk("mr_rd_rdata", rsp_rdata, 8'h31);
    chk("mr_rd_err", rsp_err, 0);
    tick;

    // Back-to-back writes with cmd_valid held high
    pready = 1'b1;
    idx = 0; nrsp = 0; nacc = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 8'h30;
    for (int c = 0; c < 40 && nrsp < 4; c++) begin
      acc = cmd_valid && cmd_ready;
      tick;
      if (acc) begin
        idx++;
        if (idx == 4) cmd_valid = 1'b0;
        else cmd_wdata = 8'h30 + 8'(idx);
      end
      if (psel && penable) begin
        if (nacc < 4) acc_data[nacc] = pwdata;
        nacc++;
      end
      if (rsp_valid) begin
        if (nrsp < 4) rsp_cyc[nrsp] = c;
        nrsp++;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_rsp_count", nrsp, 4);
    chk("b2b_access_count", nacc, 4);
    chk("b2b_accepted", idx, 4);
    if (nrsp == 4) begin
      for (int k = 1; k < 4; k++) chk($sformatf("b2b_gap%0d", k), rsp_cyc[k] - rsp_cyc[k-1], 3);
    end
    if (nacc == 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("b2b_pwdata%0d", k), acc_data[k], 8'h30 + k);
    end
    chk("b2b_paddr", paddr, 8'h01);
    tick; tick;
    chk("b2b_idle_psel", psel, 0);
    chk("b2b_no_extra_rsp", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
